// File: rtl/mem_stage.sv
// LC-3b MEM stage: sequences single and indirect data-memory accesses and owns the MEM/WB latch.
// Control word bit map: [0] dmem_read, [1] dmem_write, [2] indirect, [3] byte_op; other bits pass through.
module mem_stage #(
    parameter bit IND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] cw_in,
    input  logic [15:0] npc_in,
    input  logic [15:0] ir_in,
    input  logic [15:0] address_in,
    input  logic [15:0] result_in,
    input  logic [15:0] store_data_in,
    input  logic [2:0]  dr_in,
    input  logic [2:0]  cc_in,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_wmask,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic        valid,
    output logic [15:0] cw,
    output logic [15:0] npc,
    output logic [15:0] ir,
    output logic [2:0]  dr,
    output logic [2:0]  cc,
    output logic [15:0] result,
    output logic [15:0] mem_data
);

    localparam int CW_DMEM_READ  = 0;
    localparam int CW_DMEM_WRITE = 1;
    localparam int CW_INDIRECT   = 2;
    localparam int CW_BYTE_OP    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_IND_RD = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] ptr_r;
    logic        memop_s;
    logic        ind_s;
    logic        done_s;
    logic [15:0] ea_s;
    logic [15:0] load_data_s;

    // Word load passes through; byte load picks the addressed half and sign-extends it.
    function automatic logic [15:0] load_value(input logic [15:0] rdata,
                                               input logic        byte_op,
                                               input logic        odd);
        logic [7:0] b;
        if (byte_op) begin
            b = odd ? rdata[15:8] : rdata[7:0];
            return {{8{b[7]}}, b};
        end else begin
            return rdata;
        end
    endfunction

    // Qualify the request, pick the effective address and form the write lanes.
    always_comb begin
        memop_s     = valid_in & (cw_in[CW_DMEM_READ] | cw_in[CW_DMEM_WRITE]);
        ind_s       = IND_EN & cw_in[CW_INDIRECT];
        ea_s        = ind_s ? ptr_r : address_in;
        done_s      = (state_r == ST_ACCESS) & dmem_resp & memop_s;
        stall       = memop_s & ~done_s;
        load_data_s = load_value(dmem_rdata, cw_in[CW_BYTE_OP], ea_s[0]);
        if (cw_in[CW_BYTE_OP]) begin
            dmem_wdata = {store_data_in[7:0], store_data_in[7:0]};
            dmem_wmask = ea_s[0] ? 2'b10 : 2'b01;
        end else begin
            dmem_wdata = store_data_in;
            dmem_wmask = 2'b11;
        end
    end

    // Access sequencer: next state and the data-memory request strobes.
    always_comb begin
        state_nxt_s  = state_r;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = {ea_s[15:1], 1'b0};
        case (state_r)
            ST_IDLE: begin
                if (memop_s) begin
                    state_nxt_s = ind_s ? ST_IND_RD : ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IND_RD: begin
                // Losing the instruction mid-sequence abandons it rather than hanging.
                if (!memop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    dmem_read    = 1'b1;
                    dmem_address = {address_in[15:1], 1'b0};
                    state_nxt_s  = dmem_resp ? ST_ACCESS : ST_IND_RD;
                end
            end
            ST_ACCESS: begin
                if (!memop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    dmem_read   = cw_in[CW_DMEM_READ];
                    dmem_write  = cw_in[CW_DMEM_WRITE] & ~cw_in[CW_DMEM_READ];
                    state_nxt_s = dmem_resp ? ST_IDLE : ST_ACCESS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and the captured indirect pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IND_RD) && memop_s && dmem_resp) begin
                ptr_r <= dmem_rdata;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // MEM/WB latch: inject a bubble while stalled, otherwise take the EX/MEM contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            cw       <= 16'h0000;
            npc      <= 16'h0000;
            ir       <= 16'h0000;
            dr       <= 3'b000;
            cc       <= 3'b000;
            result   <= 16'h0000;
            mem_data <= 16'h0000;
        end else if (stall) begin
            valid <= 1'b0;
        end else begin
            valid  <= valid_in;
            cw     <= cw_in;
            npc    <= npc_in;
            ir     <= ir_in;
            dr     <= dr_in;
            cc     <= cc_in;
            result <= result_in;
            if (done_s && cw_in[CW_DMEM_READ]) begin
                mem_data <= load_data_s;
            end else begin
                mem_data <= mem_data;
            end
        end
    end

endmodule
